// File: rtl/apb_cnt_sequencer.sv
// APB master that runs one clock-count measurement: write START, wait a window,
// write STOP, then read back COUNT and STATUS and report them on a done pulse.
module apb_cnt_sequencer #(
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] START_ADDR  = 32'h0,
    parameter logic [31:0] STOP_ADDR   = 32'h4,
    parameter logic [31:0] STATUS_ADDR = 32'h8,
    parameter logic [31:0] COUNT_ADDR  = 32'hC
) (
    input  logic             p_clk,
    input  logic             prst,
    input  logic             go,
    input  logic [WIN_W-1:0] window,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             result_status,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [31:0]      m_paddr,
    output logic             m_psel,
    output logic             m_penable,
    output logic             m_pwrite,
    output logic [31:0]      m_pwdata,
    input  logic             m_pready,
    input  logic [31:0]      m_prdata,
    input  logic             m_pslverr
);

    localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SLAVE = 2'b01;
    localparam logic [1:0] ERR_TOUT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_START,
        S_WAIT_WIN,
        S_WR_STOP,
        S_RD_COUNT,
        S_RD_STATUS,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic              access, access_nx;
    logic [WIN_W-1:0]  wcnt;
    logic [TO_W-1:0]   tcnt;

    logic              apb_state;
    logic              accept;
    logic              xfer_ok;
    logic              xfer_err;
    logic              xfer_to;

    // access marks the ACCESS phase of the transfer owned by the current state
    always_ff @(posedge p_clk or posedge prst) begin
        if (prst) begin
            state  <= S_IDLE;
            access <= 1'b0;
        end else begin
            state  <= state_nx;
            access <= access_nx;
        end
    end

    always_comb begin
        apb_state = (state == S_WR_START) || (state == S_WR_STOP) ||
                    (state == S_RD_COUNT) || (state == S_RD_STATUS);
        accept    = (state == S_IDLE) && go;
        xfer_ok   = apb_state && access && m_pready && !m_pslverr;
        xfer_err  = apb_state && access && m_pready && m_pslverr;
        xfer_to   = apb_state && access && !m_pready && (tcnt == TO_W'(TIMEOUT));

        state_nx  = state;
        access_nx = access;

        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_nx = S_WR_START;
                end
            end
            S_WAIT_WIN: begin
                if (wcnt == WIN_W'(1)) begin
                    state_nx = S_WR_STOP;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                if (!access) begin
                    access_nx = 1'b1;
                end else if (xfer_err || xfer_to) begin
                    access_nx = 1'b0;
                    state_nx  = S_DONE;
                end else if (xfer_ok) begin
                    access_nx = 1'b0;
                    unique case (state)
                        S_WR_START:  state_nx = (wcnt == '0) ? S_WR_STOP : S_WAIT_WIN;
                        S_WR_STOP:   state_nx = S_RD_COUNT;
                        S_RD_COUNT:  state_nx = S_RD_STATUS;
                        default:     state_nx = S_DONE;
                    endcase
                end
            end
        endcase
    end

    // Bus outputs decode from registered state, so reset drops them asynchronously
    always_comb begin
        m_psel    = apb_state;
        m_penable = apb_state && access;
        m_paddr   = '0;
        m_pwrite  = 1'b0;
        m_pwdata  = '0;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        unique case (state)
            S_WR_START: begin
                m_paddr  = START_ADDR;
                m_pwrite = 1'b1;
                m_pwdata = 32'h1;
            end
            S_WR_STOP: begin
                m_paddr  = STOP_ADDR;
                m_pwrite = 1'b1;
                m_pwdata = 32'h1;
            end
            S_RD_COUNT:  m_paddr = COUNT_ADDR;
            S_RD_STATUS: m_paddr = STATUS_ADDR;
            default: ;
        endcase
    end

    // wcnt holds the latched window and counts it down inside WAIT_WIN
    always_ff @(posedge p_clk or posedge prst) begin
        if (prst) begin
            wcnt <= '0;
        end else if (accept) begin
            wcnt <= window;
        end else if (state == S_WAIT_WIN) begin
            wcnt <= wcnt - WIN_W'(1);
        end
    end

    always_ff @(posedge p_clk or posedge prst) begin
        if (prst) begin
            tcnt <= '0;
        end else if (apb_state && !access) begin
            tcnt <= TO_W'(1);
        end else if (apb_state && access && !m_pready) begin
            tcnt <= tcnt + TO_W'(1);
        end
    end

    always_ff @(posedge p_clk or posedge prst) begin
        if (prst) begin
            result        <= '0;
            result_status <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
        end else if (accept) begin
            result        <= '0;
            result_status <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            if (xfer_ok && (state == S_RD_COUNT)) begin
                result <= m_prdata;
            end
            if (xfer_ok && (state == S_RD_STATUS)) begin
                result_status <= m_prdata[0];
            end
            if (xfer_err) begin
                err      <= 1'b1;
                err_code <= ERR_SLAVE;
            end else if (xfer_to) begin
                err      <= 1'b1;
                err_code <= ERR_TOUT;
            end
        end
    end

endmodule

// File: tb/tb_apb_cnt_sequencer.sv
// Directed bench for apb_cnt_sequencer: behavioural APB slave plus a queue of
// expected transfers checked at every SETUP, and per-run timing/result checks.
module tb_apb_cnt_sequencer;

    localparam logic [31:0] A_START  = 32'h0;
    localparam logic [31:0] A_STOP   = 32'h4;
    localparam logic [31:0] A_STATUS = 32'h8;
    localparam logic [31:0] A_COUNT  = 32'hC;

    logic        clk = 1'b0;
    logic        prst;
    logic        go;
    logic [15:0] window;
    logic        busy, done, result_status, err;
    logic [31:0] result;
    logic [1:0]  err_code;
    logic [31:0] m_paddr, m_pwdata, m_prdata;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;

    // slave configuration
    int          wait_n  = 0;
    logic        stuck   = 1'b0;
    logic        err_en  = 1'b0;
    logic [31:0] err_addr = '0;
    int          acc_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [64:0] held;

    apb_cnt_sequencer #(.WIN_W(16), .TIMEOUT(4)) dut (
        .p_clk(clk), .prst(prst), .go(go), .window(window),
        .busy(busy), .done(done), .result(result), .result_status(result_status),
        .err(err), .err_code(err_code),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr)
    );

    always #5 clk = ~clk;

    assign m_pready  = m_psel && m_penable && !stuck && (acc_cnt >= wait_n);
    assign m_pslverr = err_en && (m_paddr == err_addr);
    assign m_prdata  = (m_paddr == A_COUNT)  ? 32'h0000_000B :
                       (m_paddr == A_STATUS) ? 32'h0000_0001 : 32'h0;

    always @(posedge clk) begin
        if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 1;
        else                                  acc_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        xfer_t x;
        x.addr  = a;
        x.write = (a == A_START) || (a == A_STOP);
        x.wdata = x.write ? 32'h1 : 32'h0;
        exp_q.push_back(x);
    endtask

    // scoreboard: pop at each SETUP, then require the bus to hold through ACCESS
    always @(negedge clk) begin
        if (!prst && m_psel) begin
            if (!m_penable) begin
                chk("unexpected_setup", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    chk("paddr", 64'(m_paddr), 64'(e.addr));
                    chk("pwrite", 64'(m_pwrite), 64'(e.write));
                    chk("pwdata", 64'(m_pwdata), 64'(e.wdata));
                end
                held = {m_paddr, m_pwrite, m_pwdata};
            end else begin
                chk("access_stable", 64'({m_paddr, m_pwrite, m_pwdata} == held), 64'd1);
            end
        end
    end

    task automatic run(input int w, input int nx, input int exp_done, input int exp_stop,
                       input int exp_acc, input logic [31:0] exp_res, input logic exp_st,
                       input logic exp_err, input logic [1:0] exp_code, input int poke);
        logic [31:0] seq [4];
        int cyc, stop_cyc, acc, done_cyc;
        seq[0] = A_START; seq[1] = A_STOP; seq[2] = A_COUNT; seq[3] = A_STATUS;
        for (int i = 0; i < nx; i++) push(seq[i]);
        @(negedge clk);
        go = 1'b1;
        window = 16'(w);
        @(negedge clk);
        go = 1'b0;
        cyc = 1; done_cyc = -1; stop_cyc = -1; acc = 0;
        while (cyc < 200) begin
            if (m_psel && m_penable) acc++;
            if (m_psel && !m_penable && m_paddr == A_STOP) stop_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            go = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        go = 1'b0;
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("stop_setup_cycle", 64'(stop_cyc), 64'(exp_stop));
        chk("access_cycles", 64'(acc), 64'(exp_acc));
        chk("busy_at_done", 64'(busy), 64'd1);
        chk("result", 64'(result), 64'(exp_res));
        chk("result_status", 64'(result_status), 64'(exp_st));
        chk("err", 64'(err), 64'(exp_err));
        chk("err_code", 64'(err_code), 64'(exp_code));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("psel_after_done", 64'(m_psel), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("result_held", 64'(result), 64'(exp_res));
    endtask

    initial begin
        int n;
        prst = 1'b1;
        go = 1'b0;
        window = '0;
        #1;
        chk("rst_outputs", 64'({busy, done, result, result_status, err, err_code}), 64'd0);
        chk("rst_bus", 64'({m_paddr, m_psel, m_penable, m_pwrite}), 64'd0);
        chk("rst_wdata", 64'(m_pwdata), 64'd0);
        @(negedge clk);
        @(negedge clk);
        prst = 1'b0;

        // nominal window 10
        run(10, 4, 19, 13, 4, 32'hB, 1'b1, 1'b0, 2'b00, -1);
        // zero window
        run(0, 4, 9, 3, 4, 32'hB, 1'b1, 1'b0, 2'b00, -1);
        // three wait states per transfer, window 5
        wait_n = 3;
        run(5, 4, 26, 11, 16, 32'hB, 1'b1, 1'b0, 2'b00, -1);
        // slave error on STOP write
        wait_n = 0; err_en = 1'b1; err_addr = A_STOP;
        run(2, 2, 7, 5, 2, 32'h0, 1'b0, 1'b1, 2'b01, -1);
        // ready+error on the TIMEOUT-th access cycle is a slave error
        wait_n = 3; err_addr = A_START;
        run(3, 1, 6, -1, 4, 32'h0, 1'b0, 1'b1, 2'b01, -1);
        // pready stuck low on START: timeout
        err_en = 1'b0; wait_n = 0; stuck = 1'b1;
        run(3, 1, 6, -1, 4, 32'h0, 1'b0, 1'b1, 2'b10, -1);
        stuck = 1'b0;

        // reset in the middle of the COUNT read ACCESS phase
        wait_n = 2;
        push(A_START); push(A_STOP); push(A_COUNT);
        @(negedge clk);
        go = 1'b1;
        window = 16'd0;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!(m_psel && m_penable && m_paddr == A_COUNT) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_count_access", 64'(n < 50), 64'd1);
        prst = 1'b1;
        #1;
        chk("rst_mid_psel", 64'(m_psel), 64'd0);
        chk("rst_mid_penable", 64'(m_penable), 64'd0);
        chk("rst_mid_outputs", 64'({busy, done, result, result_status, err, err_code}), 64'd0);
        chk("rst_mid_bus", 64'({m_paddr, m_pwrite, m_pwdata}), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_in_reset", 64'(done), 64'd0);
        end
        prst = 1'b0;
        wait_n = 0;
        // clean run afterwards with a stray go pulse while busy
        run(1, 4, 10, 4, 4, 32'hB, 1'b1, 1'b0, 2'b00, 5);
        @(negedge clk);
        chk("stray_go_ignored", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_cnt_sequencer.md
# apb_cnt_sequencer

APB master that runs one clock-count measurement on the APB clock counter slave. A single `go` pulse makes it write START, wait a programmable window, write STOP, then read back COUNT and STATUS. The result is returned on a `done` pulse. The block sits between system control logic and the counter's APB port and is that port's only master.

## Interface
- `WIN_W`, 16: width of the measurement window length.
- `TIMEOUT`, 255: maximum number of ACCESS cycles waiting for `m_pready` before the transfer is aborted. Must be ≥1.
- `START_ADDR`, 32'h0: START register address.
- `STOP_ADDR`, 32'h4: STOP register address.
- `STATUS_ADDR`, 32'h8: STATUS register address.
- `COUNT_ADDR`, 32'hC: COUNT register address.

Ports:
- `p_clk` input 1: single clock for the whole block.
- `prst` input 1: reset, asynchronous, active-high.
- `go` input 1: start request; sampled only in IDLE.
- `window` input WIN_W: window length in cycles; latched when `go` is accepted.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `result` output 32: COUNT value read back.
- `result_status` output 1: bit 0 of STATUS read back.
- `err` output 1: the sequence aborted.
- `err_code` output 2: 01 = slave error, 10 = timeout, 00 = none.
- `m_paddr` output 32: APB address.
- `m_psel` output 1: APB select.
- `m_penable` output 1: APB enable.
- `m_pwrite` output 1: APB write.
- `m_pwdata` output 32: APB write data.
- `m_pready` input 1: APB ready.
- `m_prdata` input 32: APB read data.
- `m_pslverr` input 1: APB slave error.

## Operation
- FSM states: IDLE, WR_START, WAIT_WIN, WR_STOP, RD_COUNT, RD_STATUS, DONE.
- Normal sequence: IDLE → WR_START → WAIT_WIN → WR_STOP → RD_COUNT → RD_STATUS → DONE → IDLE.
- Each APB state runs one transfer:
  - SETUP phase: 1 cycle, `m_psel`=1, `m_penable`=0.
  - ACCESS phase: `m_psel`=1, `m_penable`=1, held until `m_pready`=1.
  - `m_paddr`, `m_pwrite` and `m_pwdata` are stable across SETUP and ACCESS.
- Write data is 32'h1 for START_ADDR and STOP_ADDR. `m_pwdata`=0 during reads.
- When `m_psel`=0, `m_paddr`, `m_pwdata` and `m_pwrite` are driven to 0.
- `go` acceptance:
  - Accepted in IDLE only; `go` in any other state (including DONE) is ignored.
  - On acceptance: latch `window`; clear `err`, `err_code`, `result` and `result_status`.
- WAIT_WIN lasts exactly `window` cycles with the bus idle. `window`=0 skips WAIT_WIN: WR_STOP SETUP follows START completion directly.
- `result` and `result_status` capture from `m_prdata` on the completing ACCESS cycle of the RD_COUNT and RD_STATUS transfers, respectively.
- `result` is the counter's raw 32-bit value. Counter wrap is not corrected.
- Slave error: `m_pslverr` is sampled only when `m_pready`=1. On an error, abort to DONE with `err`=1 and `err_code`=01. The remaining transfers are skipped, so the counter may be left running.
- Timeout: ACCESS cycles are counted from 1. If `m_pready`=0 on ACCESS cycle TIMEOUT, the next cycle is DONE with `psel`/`penable` low, `err`=1 and `err_code`=10. The timeout counter resets at every new SETUP.
- `m_pready`=1 together with `m_pslverr`=1 on the TIMEOUT-th cycle is a slave error (01), not a timeout.
- DONE: `done`=1 for one cycle; `busy` stays 1; the next state is IDLE.
- `result`, `result_status`, `err` and `err_code` hold their values until the next accepted `go` or a reset.

## Timing
- Reset values: every output is 0, including all `m_*` outputs, `busy`, `done`, `result` and `err_code`. Reset forces the FSM to IDLE.
- Reset mid-transfer: `m_psel` and `m_penable` drop asynchronously, with no completion and no `done`.
- Cycle numbering: `go` is sampled at the edge ending cycle 0. With zero-wait `m_pready`:
  - START SETUP/ACCESS: cycles 1-2.
  - WAIT_WIN: cycles 3..2+W, where W is the latched `window`.
  - STOP: cycles 3+W..4+W.
  - COUNT read: cycles 5+W..6+W.
  - STATUS read: cycles 7+W..8+W.
  - `done`: cycle 9+W.
- Each wait state on `m_pready` adds exactly 1 cycle.
- Back-to-back measurements: `go` held high re-triggers in the IDLE cycle after DONE, giving a minimum period of 10+W cycles.
- Timeout abort: `done` is asserted TIMEOUT+1 cycles after the failing SETUP cycle.

## Test plan
- Nominal run: `window`=10, slave always ready, `m_prdata`=32'h0000_000B for COUNT and 32'h1 for STATUS. Required: `done` at cycle 19, `result`=32'hB, `result_status`=1, `err`=0, and the APB address order 0x0, 0x4, 0xC, 0x8.
- Zero window: `window`=0. Required: STOP SETUP at cycle 3 and `done` at cycle 9.
- Wait states: `m_pready` held low for 3 ACCESS cycles on every transfer, `window`=5. Required: `done` at cycle 26, with address, write and data stable during each wait.
- Slave error on the STOP write. Required: no further transfers, `done` the next cycle, `err`=1, `err_code`=01, `result`=0.
- Timeout: TIMEOUT=4 and `m_pready` stuck low on START. Required: four ACCESS cycles, then DONE with `err_code`=10, then IDLE.
- Asynchronous reset: `prst` asserted mid-ACCESS of RD_COUNT. Required: `psel`/`penable` drop immediately, all outputs 0, no `done`. After release, a new `go` runs a clean sequence; a `go` pulse during `busy` is ignored.
